complete_multi: RTL and testbench

//  Parametrised multi-lane complete stage. Accepts EX_CO_PACKETs from NUM_LANES execute lanes,

---
 rtl/complete_multi_pkg.sv | 75 +++++++
 rtl/complete_multi_lane_fifo.sv | 74 +++++++
 rtl/complete_multi.sv | 156 +++++++++++++++
 tb/tb_complete_multi.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/complete_multi_pkg.sv
// Shared completion-stage types and machine-wide sizing macros.
// Defines the EX->CO and CO->RE bundles plus FU bookkeeping helpers.
`ifndef SYS_DEFS_MACROS
`define SYS_DEFS_MACROS
`define XLEN 32
`define PHYS_REG_IDX_SZ 5
`define ZERO_REG {(`PHYS_REG_IDX_SZ+1){1'b0}}
`define NUM_FU_ALU 4
`define NUM_FU_MULT 2
`define NUM_FU_BRANCH 2
`define NUM_FU_LOAD 2
`define NUM_FU_STORE 2
`define MAX_FU_INDEX 4
`define NUM_CO_LANES 4
`define NUM_CDB 2
`define CO_QUEUE_DEPTH 2
`endif

package sys_defs;

    localparam int PREG_W    = `PHYS_REG_IDX_SZ + 1;
    localparam int MAXFU     = `MAX_FU_INDEX;
    localparam int FU_IDX_W  = $clog2(MAXFU);
    localparam int ROB_IDX_W = 5;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MULT   = 3'd1,
        FU_BRANCH = 3'd2,
        FU_LOAD   = 3'd3,
        FU_STORE  = 3'd4
    } FU_TYPE;

    typedef struct packed {
        logic                 valid;
        logic [`XLEN-1:0]     NPC;
        logic [`XLEN-1:0]     result;
        logic                 take_branch;
        logic [PREG_W-1:0]    dest_reg_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        FU_TYPE               function_type;
        logic [FU_IDX_W-1:0]  issued_fu_index;
        logic                 halt;
        logic                 illegal;
    } EX_CO_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [`XLEN-1:0]     NPC;
        logic [`XLEN-1:0]     result;
        logic                 take_branch;
        logic [PREG_W-1:0]    dest_reg_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        FU_TYPE               function_type;
        logic [FU_IDX_W-1:0]  issued_fu_index;
        logic                 halt;
        logic                 illegal;
        logic                 regfile_en;
        logic [PREG_W-1:0]    regfile_idx;
        logic [`XLEN-1:0]     regfile_data;
    } CO_RE_PACKET;

    // Branches write back the link address, everything else its result
    function automatic logic [`XLEN-1:0] wb_data(input EX_CO_PACKET p);
        return p.take_branch ? p.NPC : p.result;
    endfunction

    // One-hot of an FU index, sized to the widest FU pool
    function automatic logic [MAXFU-1:0] fu_onehot(input logic [FU_IDX_W-1:0] idx);
        logic [MAXFU-1:0] one;
        one = {{(MAXFU-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/complete_multi_lane_fifo.sv
// Per-lane completion FIFO: push/pop/flush with power-of-2 depth.
// Pointers wrap naturally; count distinguishes full from empty.
module complete_lane_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  EX_CO_PACKET              din,
    output EX_CO_PACKET              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    EX_CO_PACKET     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign do_push  = push & (count_q != FULL);
    assign do_pop   = pop & (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign not_full = (count_q != FULL);

    // Next pointer/count; flush drops all entries
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/complete_multi.sv
// Multi-lane complete stage: lane FIFOs, RR multi-grant onto the CDB.
// Define COMPLETE_BYPASS_EN to let an empty lane's push broadcast same cycle.
module complete_multi
    import sys_defs::*;
#(
    parameter int NUM_LANES   = `NUM_CO_LANES,
    parameter int NUM_CDB     = `NUM_CDB,
    parameter int QUEUE_DEPTH = `CO_QUEUE_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  EX_CO_PACKET              ex_co_reg [NUM_LANES],
    output logic [NUM_LANES-1:0]     lane_ready,
    input  logic                     rollback,
    output CO_RE_PACKET              co_packet [NUM_CDB],
    output logic [NUM_CDB-1:0]       co_output_en,
    output logic [PREG_W-1:0]        co_output_idx [NUM_CDB],
    output logic [`XLEN-1:0]         co_output_data [NUM_CDB],
    output logic [`NUM_FU_ALU-1:0]    free_alu,
    output logic [`NUM_FU_MULT-1:0]   free_mult,
    output logic [`NUM_FU_BRANCH-1:0] free_branch,
    output logic [`NUM_FU_LOAD-1:0]   free_load,
    output logic [`NUM_FU_STORE-1:0]  free_store
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    EX_CO_PACKET          head     [NUM_LANES];
    EX_CO_PACKET          cand_pkt [NUM_LANES];
    logic [CNT_W-1:0]     count    [NUM_LANES];
    logic [NUM_LANES-1:0] empty, accept, cand, grant, push, pop;
    logic [PTR_W-1:0]     port_lane [NUM_CDB];
    logic [NUM_CDB-1:0]   port_vld;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign accept[i] = ex_co_reg[i].valid & lane_ready[i] & ~rollback & ~reset;
        assign empty[i]  = (count[i] == '0);
        assign pop[i]    = grant[i] & ~empty[i] & ~rollback;
`ifdef COMPLETE_BYPASS_EN
        assign cand[i]     = ~empty[i] | accept[i];
        assign cand_pkt[i] = empty[i] ? ex_co_reg[i] : head[i];
        assign push[i]     = accept[i] & ~(grant[i] & empty[i]);
`else
        assign cand[i]     = ~empty[i];
        assign cand_pkt[i] = head[i];
        assign push[i]     = accept[i];
`endif

        complete_lane_fifo #(
            .DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .flush    (rollback),
            .push     (push[i]),
            .pop      (pop[i]),
            .din      (ex_co_reg[i]),
            .head     (head[i]),
            .count    (count[i]),
            .not_full (lane_ready[i])
        );
    end

    // Round-robin scan from the pointer, granting up to NUM_CDB lanes
    always_comb begin
        int n;
        int lane;
        grant    = '0;
        port_vld = '0;
        rr_ptr_d = rr_ptr_q;
        n        = 0;
        lane     = 0;
        for (int k = 0; k < NUM_CDB; k++) begin
            port_lane[k] = '0;
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            lane = int'(rr_ptr_q) + j;
            if (lane >= NUM_LANES) lane = lane - NUM_LANES;
            if (cand[lane] && (n < NUM_CDB)) begin
                grant[lane]  = 1'b1;
                port_vld[n]  = 1'b1;
                port_lane[n] = PTR_W'(lane);
                rr_ptr_d     = (lane == NUM_LANES - 1) ? '0 : PTR_W'(lane + 1);
                n            = n + 1;
            end
        end
        if (rollback) rr_ptr_d = rr_ptr_q;
    end

    // Arbiter pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Drive each CDB port from its granted head; idle ports stay zero
    always_comb begin
        EX_CO_PACKET p;
        p = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            co_packet[k]      = '0;
            co_output_en[k]   = 1'b0;
            co_output_idx[k]  = '0;
            co_output_data[k] = '0;
            p = cand_pkt[port_lane[k]];
            if (port_vld[k] && !rollback && !reset) begin
                co_packet[k].valid           = p.valid;
                co_packet[k].NPC             = p.NPC;
                co_packet[k].result          = p.result;
                co_packet[k].take_branch     = p.take_branch;
                co_packet[k].dest_reg_idx    = p.dest_reg_idx;
                co_packet[k].rob_idx         = p.rob_idx;
                co_packet[k].function_type   = p.function_type;
                co_packet[k].issued_fu_index = p.issued_fu_index;
                co_packet[k].halt            = p.halt;
                co_packet[k].illegal         = p.illegal;
                co_output_en[k]   = p.valid & (p.dest_reg_idx != `ZERO_REG);
                co_output_idx[k]  = p.dest_reg_idx;
                co_output_data[k] = wb_data(p);
                co_packet[k].regfile_en   = co_output_en[k];
                co_packet[k].regfile_idx  = co_output_idx[k];
                co_packet[k].regfile_data = co_output_data[k];
            end
        end
    end

    // FU release pulses for every lane accepted this cycle
    always_comb begin
        logic [MAXFU-1:0] oh;
        oh          = '0;
        free_alu    = '0;
        free_mult   = '0;
        free_branch = '0;
        free_load   = '0;
        free_store  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            oh = fu_onehot(ex_co_reg[i].issued_fu_index);
            if (accept[i] && !ex_co_reg[i].halt && !ex_co_reg[i].illegal) begin
                unique case (ex_co_reg[i].function_type)
                    FU_ALU:    free_alu    = free_alu    | oh[`NUM_FU_ALU-1:0];
                    FU_MULT:   free_mult   = free_mult   | oh[`NUM_FU_MULT-1:0];
                    FU_BRANCH: free_branch = free_branch | oh[`NUM_FU_BRANCH-1:0];
                    FU_LOAD:   free_load   = free_load   | oh[`NUM_FU_LOAD-1:0];
                    FU_STORE:  free_store  = free_store  | oh[`NUM_FU_STORE-1:0];
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_complete_multi.sv
// Directed bench for complete_multi: latency, RR order, backpressure,
// writeback selection, rollback and the optional bypass path.
module tb_complete_multi;
    import sys_defs::*;

    localparam int NL = 4;
    localparam int NC = 2;
    localparam int QD = 2;
`ifdef COMPLETE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic rollback;
    EX_CO_PACKET ex_co_reg [NL];
    logic [NL-1:0] lane_ready;
    CO_RE_PACKET co_packet [NC];
    logic [NC-1:0] co_output_en;
    logic [PREG_W-1:0] co_output_idx [NC];
    logic [`XLEN-1:0] co_output_data [NC];
    logic [`NUM_FU_ALU-1:0] free_alu;
    logic [`NUM_FU_MULT-1:0] free_mult;
    logic [`NUM_FU_BRANCH-1:0] free_branch;
    logic [`NUM_FU_LOAD-1:0] free_load;
    logic [`NUM_FU_STORE-1:0] free_store;

    int checks = 0;
    int passes = 0;
    logic [31:0] rec [$];

    always #5 clock = ~clock;

    complete_multi #(
        .NUM_LANES(NL), .NUM_CDB(NC), .QUEUE_DEPTH(QD)
    ) dut (
        .clock(clock), .reset(reset), .ex_co_reg(ex_co_reg),
        .lane_ready(lane_ready), .rollback(rollback),
        .co_packet(co_packet), .co_output_en(co_output_en),
        .co_output_idx(co_output_idx), .co_output_data(co_output_data),
        .free_alu(free_alu), .free_mult(free_mult),
        .free_branch(free_branch), .free_load(free_load),
        .free_store(free_store)
    );

    function automatic EX_CO_PACKET mk(input FU_TYPE ft, input int fu, input int dest,
                                       input logic [31:0] res, input logic [31:0] npc,
                                       input logic tb);
        EX_CO_PACKET p;
        p = '0;
        p.valid = 1'b1;
        p.function_type = ft;
        p.issued_fu_index = FU_IDX_W'(fu);
        p.dest_reg_idx = PREG_W'(dest);
        p.rob_idx = ROB_IDX_W'(dest);
        p.result = res;
        p.NPC = npc;
        p.take_branch = tb;
        return p;
    endfunction

    task automatic clear_in;
        for (int i = 0; i < NL; i++) ex_co_reg[i] = '0;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        rollback = 1'b0;
        clear_in();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic sample_lane2;
        for (int k = 0; k < NC; k++)
            if (co_packet[k].valid && co_output_data[k][31:28] == 4'hA)
                rec.push_back(co_output_data[k]);
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++; if (lane_ready !== 4'hF) $display("FAIL reset_ready got %h exp f", lane_ready); else passes++;
        checks++; if (co_output_en !== 2'b00) $display("FAIL reset_en got %b exp 00", co_output_en); else passes++;
        checks++; if ({co_packet[0].valid, co_packet[1].valid} !== 2'b00) $display("FAIL reset_valid got %b exp 00", {co_packet[0].valid, co_packet[1].valid}); else passes++;
        checks++; if ({free_alu, free_mult, free_branch, free_load, free_store} !== '0) $display("FAIL reset_free got nonzero exp 0"); else passes++;
        checks++; if (co_output_data[0] !== 32'h0) $display("FAIL reset_data got %h exp 0", co_output_data[0]); else passes++;
    endtask

    task automatic test_single_alu;
        do_reset();
        ex_co_reg[0] = mk(FU_ALU, 1, 5, 32'h2A, 32'h0, 1'b0);
        #1;
        checks++; if (free_alu !== 4'b0010) $display("FAIL t1_free_alu got %b exp 0010", free_alu); else passes++;
        checks++; if (co_packet[0].valid !== BYP) $display("FAIL t1_push_cycle_valid got %b exp %b", co_packet[0].valid, BYP); else passes++;
        tick();
        clear_in();
        #1;
        if (!BYP) begin
            checks++; if (co_packet[0].valid !== 1'b1) $display("FAIL t1_valid got %b exp 1", co_packet[0].valid); else passes++;
            checks++; if (co_output_en[0] !== 1'b1) $display("FAIL t1_en got %b exp 1", co_output_en[0]); else passes++;
            checks++; if (co_output_idx[0] !== 6'd5) $display("FAIL t1_idx got %0d exp 5", co_output_idx[0]); else passes++;
            checks++; if (co_output_data[0] !== 32'h2A) $display("FAIL t1_data got %h exp 2a", co_output_data[0]); else passes++;
        end
        checks++; if (free_alu !== 4'b0000) $display("FAIL t1_free_after got %b exp 0000", free_alu); else passes++;
        tick();
        #1;
        checks++; if (co_packet[0].valid !== 1'b0) $display("FAIL t1_drained got %b exp 0", co_packet[0].valid); else passes++;
    endtask

    task automatic test_rr_all_lanes;
        do_reset();
        for (int i = 0; i < NL; i++) ex_co_reg[i] = mk(FU_ALU, i, i + 1, 32'h10 + i, 32'h0, 1'b0);
        #1;
        checks++; if (free_alu !== 4'b1111) $display("FAIL t2_free got %b exp 1111", free_alu); else passes++;
        tick();
        clear_in();
        #1;
        checks++; if (co_output_data[0] !== 32'h10 || co_output_idx[0] !== 6'd1) $display("FAIL t2_c1_p0 got %h/%0d exp 10/1", co_output_data[0], co_output_idx[0]); else passes++;
        checks++; if (co_output_data[1] !== 32'h11 || !co_packet[1].valid) $display("FAIL t2_c1_p1 got %h exp 11", co_output_data[1]); else passes++;
        tick();
        #1;
        checks++; if (co_output_data[0] !== 32'h12) $display("FAIL t2_c2_p0 got %h exp 12", co_output_data[0]); else passes++;
        checks++; if (co_output_data[1] !== 32'h13) $display("FAIL t2_c2_p1 got %h exp 13", co_output_data[1]); else passes++;
        tick();
        ex_co_reg[0] = mk(FU_ALU, 0, 1, 32'h20, 32'h0, 1'b0);
        ex_co_reg[1] = mk(FU_ALU, 1, 2, 32'h21, 32'h0, 1'b0);
        #1;
        checks++; if (co_packet[0].valid !== BYP) $display("FAIL t2_idle got %b exp %b", co_packet[0].valid, BYP); else passes++;
        tick();
        clear_in();
        #1;
        if (!BYP) begin
            checks++; if (co_output_data[0] !== 32'h20 || co_output_data[1] !== 32'h21) $display("FAIL t2_ptr_wrap got %h,%h exp 20,21", co_output_data[0], co_output_data[1]); else passes++;
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        rec.delete();
        ex_co_reg[0] = mk(FU_ALU, 0, 1, 32'h30, 32'h0, 1'b0);
        ex_co_reg[1] = mk(FU_ALU, 1, 2, 32'h31, 32'h0, 1'b0);
        ex_co_reg[2] = mk(FU_MULT, 1, 3, 32'hA0, 32'h0, 1'b0);
        ex_co_reg[3] = mk(FU_ALU, 3, 4, 32'h33, 32'h0, 1'b0);
        ex_co_reg[2].result = 32'hA000_0000;
        #1 sample_lane2();
        tick();
        clear_in();
        ex_co_reg[0] = mk(FU_ALU, 0, 1, 32'h34, 32'h0, 1'b0);
        ex_co_reg[1] = mk(FU_ALU, 1, 2, 32'h35, 32'h0, 1'b0);
        ex_co_reg[2] = mk(FU_MULT, 1, 3, 32'hA000_0001, 32'h0, 1'b0);
        #1;
        checks++; if (lane_ready[2] !== 1'b1) $display("FAIL t3_ready_c1 got %b exp 1", lane_ready[2]); else passes++;
        sample_lane2();
        tick();
        clear_in();
        ex_co_reg[2] = mk(FU_MULT, 1, 3, 32'hA000_0002, 32'h0, 1'b0);
        #1;
        checks++; if (lane_ready[2] !== 1'b0) $display("FAIL t3_full got %b exp 0", lane_ready[2]); else passes++;
        checks++; if (free_mult !== 2'b00) $display("FAIL t3_held_free got %b exp 00", free_mult); else passes++;
        sample_lane2();
        tick();
        #1;
        checks++; if (lane_ready[2] !== 1'b1) $display("FAIL t3_ready_c3 got %b exp 1", lane_ready[2]); else passes++;
        checks++; if (free_mult !== 2'b10) $display("FAIL t3_accept_free got %b exp 10", free_mult); else passes++;
        sample_lane2();
        for (int c = 0; c < 6; c++) begin
            tick();
            clear_in();
            #1 sample_lane2();
        end
        checks++; if (rec.size() !== 3) $display("FAIL t3_count got %0d exp 3", rec.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rec.size() || rec[i] !== (32'hA000_0000 + 32'(i)))
                $display("FAIL t3_order_%0d got %h exp %h", i, (i < rec.size()) ? rec[i] : 32'hx, 32'hA000_0000 + 32'(i));
            else passes++;
        end
    endtask

    task automatic test_branch_zero;
        do_reset();
        ex_co_reg[1] = mk(FU_BRANCH, 0, 7, 32'h200, 32'h104, 1'b1);
        ex_co_reg[3] = mk(FU_ALU, 2, 0, 32'h55, 32'h0, 1'b0);
        #1;
        checks++; if (free_branch !== 2'b01 || free_alu !== 4'b0100) $display("FAIL t4_free got %b/%b exp 01/0100", free_branch, free_alu); else passes++;
        tick();
        clear_in();
        #1;
        if (!BYP) begin
            checks++; if (co_output_data[0] !== 32'h104) $display("FAIL t4_npc got %h exp 104", co_output_data[0]); else passes++;
            checks++; if (co_output_en[0] !== 1'b1 || co_output_idx[0] !== 6'd7) $display("FAIL t4_en_idx got %b/%0d exp 1/7", co_output_en[0], co_output_idx[0]); else passes++;
            checks++; if (co_packet[0].regfile_data !== 32'h104) $display("FAIL t4_rf_data got %h exp 104", co_packet[0].regfile_data); else passes++;
            checks++; if (co_packet[1].valid !== 1'b1 || co_output_en[1] !== 1'b0) $display("FAIL t4_zero got v%b en%b exp v1 en0", co_packet[1].valid, co_output_en[1]); else passes++;
            checks++; if (co_output_data[1] !== 32'h55) $display("FAIL t4_zero_data got %h exp 55", co_output_data[1]); else passes++;
        end
    endtask

    task automatic test_rollback;
        do_reset();
        for (int i = 0; i < 3; i++) ex_co_reg[i] = mk(FU_ALU, i, i + 1, 32'h40 + i, 32'h0, 1'b0);
        tick();
        clear_in();
        rollback = 1'b1;
        ex_co_reg[3] = mk(FU_ALU, 3, 4, 32'h43, 32'h0, 1'b0);
        #1;
        checks++; if ({co_packet[0].valid, co_packet[1].valid} !== 2'b00) $display("FAIL t5_valid got %b exp 00", {co_packet[0].valid, co_packet[1].valid}); else passes++;
        checks++; if (co_output_en !== 2'b00) $display("FAIL t5_en got %b exp 00", co_output_en); else passes++;
        checks++; if ({free_alu, free_mult, free_branch, free_load, free_store} !== '0) $display("FAIL t5_free got %b exp 0", free_alu); else passes++;
        tick();
        rollback = 1'b0;
        clear_in();
        #1;
        checks++; if (lane_ready !== 4'hF) $display("FAIL t5_ready got %h exp f", lane_ready); else passes++;
        checks++; if ({co_packet[0].valid, co_packet[1].valid} !== 2'b00) $display("FAIL t5_after got %b exp 00", {co_packet[0].valid, co_packet[1].valid}); else passes++;
        tick();
        #1;
        checks++; if ({co_packet[0].valid, co_packet[1].valid} !== 2'b00) $display("FAIL t5_dropped got %b exp 00", {co_packet[0].valid, co_packet[1].valid}); else passes++;
    endtask

    task automatic test_latency;
        do_reset();
        ex_co_reg[0] = mk(FU_LOAD, 1, 9, 32'h66, 32'h0, 1'b0);
        #1;
        checks++; if (co_packet[0].valid !== BYP) $display("FAIL t6_same got %b exp %b", co_packet[0].valid, BYP); else passes++;
        checks++; if (free_load !== 2'b10) $display("FAIL t6_free got %b exp 10", free_load); else passes++;
        tick();
        clear_in();
        #1;
        checks++; if (co_packet[0].valid !== ~BYP) $display("FAIL t6_next got %b exp %b", co_packet[0].valid, ~BYP); else passes++;
        checks++; if (co_output_data[0] !== (BYP ? 32'h0 : 32'h66)) $display("FAIL t6_data got %h", co_output_data[0]); else passes++;
        tick();
        #1;
        checks++; if (co_packet[0].valid !== 1'b0) $display("FAIL t6_empty got %b exp 0", co_packet[0].valid); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        rollback = 1'b0;
        clear_in();
        test_reset();
        test_single_alu();
        test_rr_all_lanes();
        test_back_to_back();
        test_branch_zero();
        test_rollback();
        test_latency();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
